// File: rtl/req_resp_responder_pkg.sv
// Shared types and constants for the request/response responder.
// Holds the processing FSM state encoding and the handshake-mode names.
package req_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam string CNFG_READY_VALID = "READY_VALID";
    localparam string CNFG_VALID_READY = "VALID_READY";

endpackage

// File: rtl/req_resp_responder_if.sv
// Request/response bus between an initiator (master) and the responder (slave).
interface req_resp_if #(
    parameter int DATA_SIZE = 16
);
    logic                 req_valid;
    logic [DATA_SIZE-1:0] req_data;
    logic                 req_ready;
    logic                 resp_valid;
    logic [DATA_SIZE-1:0] resp_data;

    modport master (
        output req_valid, req_data,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/req_resp_responder_fifo.sv
// Request buffer: power-of-two FIFO with extra-bit pointers and a free-entry count.
module req_resp_fifo #(
    parameter int DATA_SIZE = 16,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [DATA_SIZE-1:0]   push_data,
    input  logic                   pop,
    output logic [DATA_SIZE-1:0]   pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] free
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("req_resp_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic                 push_ok, pop_ok;

    // Same index with opposite wrap bits means the writer has lapped the reader.
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign free     = (AW+1)'(DEPTH) - (wr_ptr_q - rd_ptr_q);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // NOTE: non-blocking assignments make every flop sample pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries hold live data.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/req_resp_responder.sv
// Request/response responder: buffers requests and returns req_data+1 after LATENCY cycles.
// Define REQ_RESP_RESPONDER_ERR_EN to add the sticky protocol-violation output err.
module req_resp_responder
    import req_resp_pkg::*;
#(
    parameter int    DATA_SIZE = 16,
    parameter string CNFG      = CNFG_READY_VALID,
    parameter int    DEPTH     = 4,
    parameter int    LATENCY   = 2
) (
    input  logic      clk,
    input  logic      rstn,
    req_resp_if.slave bus
`ifdef REQ_RESP_RESPONDER_ERR_EN
    ,
    output logic      err
`endif
);
    localparam bit IS_RV = (CNFG == CNFG_READY_VALID);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    if (CNFG != CNFG_READY_VALID && CNFG != CNFG_VALID_READY) begin : g_bad_cnfg
        $error("req_resp_responder: unknown CNFG \"%s\"", CNFG);
    end
    if (LATENCY < 1) begin : g_bad_latency
        $error("req_resp_responder: LATENCY must be at least 1");
    end

    logic                 push, pop, start;
    logic                 fifo_full, fifo_empty;
    logic [AW:0]          fifo_free, free_next;
    logic [DATA_SIZE-1:0] fifo_rdata;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic                 ready_q, ready_d;

    req_resp_fifo #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (bus.req_data),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .free      (fifo_free)
    );

    // Both modes push whenever a valid request meets a non-full FIFO; only req_ready differs.
    assign push      = bus.req_valid && !fifo_full;
    assign free_next = fifo_free - (AW+1)'(push) + (AW+1)'(pop);
    assign ready_d   = IS_RV && (free_next >= (AW+1)'(2));

    assign bus.req_ready  = IS_RV ? ready_q : (rstn && bus.req_valid && !fifo_full);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_data  = (state_q == RESP) ? data_q : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        start   = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: start = !fifo_empty;
            BUSY: begin
                if (cnt_q == CW'(LATENCY - 1)) state_d = RESP;
                else                           cnt_d   = cnt_q + CW'(1);
            end
            RESP: begin
                start   = !fifo_empty;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Popping computes the response up front; BUSY only models the processing delay.
        if (start) begin
            pop     = 1'b1;
            data_d  = fifo_rdata + DATA_SIZE'(1);
            cnt_d   = '0;
            state_d = BUSY;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end

`ifdef REQ_RESP_RESPONDER_ERR_EN
    logic err_q, err_d;

    assign err_d = err_q || (bus.req_valid && fifo_full);
    assign err   = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) err_q <= 1'b0;
        else       err_q <= err_d;
    end
`endif

endmodule

// File: doc/req_resp_responder.md
REQ_RESP_RESPONDER -- requirements
Module: req_resp_responder

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 16: width of request and response data.
REQ-002 The block SHALL have parameter CNFG (string), default "READY_VALID": request handshake mode, "READY_VALID" or "VALID_READY".
REQ-003 The block SHALL have parameter DEPTH, default 4: request FIFO entries, power of two, at least 2.
REQ-004 The block SHALL have parameter LATENCY, default 2: processing cycles per request, at least 1.
REQ-005 clk  input  1  the single clock; all state changes on the rising edge.
REQ-006 rstn  input  1  reset; asynchronous and active-low.
REQ-007 req_valid  input  1  request valid from the initiator.
REQ-008 req_data  input  DATA_SIZE  request payload.
REQ-009 req_ready  output  1  responder can accept a request.
REQ-010 resp_valid  output  1  one-cycle response strobe; there is no backpressure.
REQ-011 resp_data  output  DATA_SIZE  response payload, valid only while resp_valid is high.
REQ-012 err  output  1  sticky protocol-violation flag; this port exists only when REQ_RESP_RESPONDER_ERR_EN is defined.

Function
REQ-013 A request SHALL be accepted on a rising edge where req_valid and req_ready are both high; the accepted req_data is pushed into the FIFO.
REQ-014 In VALID_READY mode, req_ready SHALL be combinational: req_valid high and FIFO not full; req_ready is never high while req_valid is low.
REQ-015 In READY_VALID mode, req_ready SHALL be registered: high when at least 2 FIFO entries are free, independent of req_valid.
REQ-016 In READY_VALID mode, every cycle with req_valid high SHALL be treated as a request; it is pushed if the FIFO is not full, otherwise dropped.
REQ-017 A response SHALL be computed as resp_data = req_data + 1, truncated modulo 2^DATA_SIZE, so 16'hFFFF yields 16'h0000.
REQ-018 The processing FSM SHALL have three states:
  - IDLE: pop when the FIFO is not empty and go to BUSY.
  - BUSY: count LATENCY cycles, then go to RESP.
  - RESP: drive resp_valid for one cycle, then go to BUSY with a pop if the FIFO is not empty, else go to IDLE.
REQ-019 Latency SHALL be exactly LATENCY+1 cycles from the accept edge to resp_valid when the FSM is IDLE; throughput SHALL be one response per LATENCY+1 cycles.
REQ-020 Responses SHALL be delivered in request order with no loss for accepted requests.
REQ-021 A simultaneous push and pop SHALL both occur in the same cycle, leaving the occupancy unchanged.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH; full and empty are distinguished by a pointer extra bit.
REQ-023 When an unknown CNFG value is elaborated, the block SHALL fail elaboration with $error.

Reset
REQ-024 While rstn is low, the block SHALL drive req_ready=0, resp_valid=0, resp_data=0 and err=0, hold the FIFO empty and the FSM in IDLE, and clear the counter.
REQ-025 A reset asserted mid-operation SHALL discard all queued and in-flight requests; no response is emitted for them after reset deasserts.
REQ-026 In READY_VALID mode, req_ready SHALL first rise on the first clock edge after rstn deasserts.

Configuration
REQ-027 When REQ_RESP_RESPONDER_ERR_EN is defined, err SHALL set on any dropped request in READY_VALID mode, or on req_valid with a full FIFO in VALID_READY mode, and stay set until reset.
REQ-028 When REQ_RESP_RESPONDER_ERR_EN is undefined, the err port and its logic SHALL be absent, and a dropped request SHALL be discarded silently.

Structure
REQ-029 The package req_resp_pkg SHALL hold the FSM state enum (IDLE, BUSY, RESP) and the CNFG string constants.
REQ-030 The request buffer SHALL be a sub-module req_resp_fifo (parameters DATA_SIZE and DEPTH; ports push, pop, full, empty, and a free count).

Verification
REQ-031 Single request (READY_VALID, LATENCY=2): request 16'h1234 -> resp_valid for exactly one cycle with resp_data=16'h1235, 3 cycles after the accept edge.
REQ-032 Wrap: request 16'hFFFF -> resp_data=16'h0000.
REQ-033 Back-to-back: 6 requests 1..6 (VALID_READY, DEPTH=4) -> req_ready drops while the FIFO is full; responses are 2..7 in order, spaced 3 cycles apart.
REQ-034 Protocol: VALID_READY with req_valid low -> req_ready is never high; READY_VALID with the FIFO at 1 free entry -> req_ready=0.
REQ-035 Reset with 3 requests queued -> all outputs are 0 during reset and no resp_valid follows.
REQ-036 ERR_EN build, READY_VALID, req_valid forced high with the FIFO full -> err=1 and stays 1 until rstn is low.
